// File: rtl/idli_sqi_arb_m.sv
// idli_sqi_arb_m: shares the SQI memory port between fetch and LSU, one full quad-SPI transaction per grant
module idli_sqi_arb_m #(
    parameter int          ADDR_NIBBLES = 6,
    parameter int          DUMMY_CYCLES = 2,
    parameter logic [7:0]  CMD_RD       = 8'h03,
    parameter logic [7:0]  CMD_WR       = 8'h02
) (
    input  logic        i_core_gck,
    input  logic        i_core_rst_n,
    input  logic        i_arb_fetch_req,
    input  logic [15:0] i_arb_fetch_addr,
    input  logic        i_arb_lsu_req,
    input  logic        i_arb_lsu_we,
    input  logic [15:0] i_arb_lsu_addr,
    input  logic [15:0] i_arb_lsu_wdata,
    output logic        o_arb_fetch_ack,
    output logic        o_arb_lsu_ack,
    output logic [15:0] o_arb_rdata,
    output logic        o_arb_busy,
    output logic        o_arb_sqi_cs,
    output logic        o_arb_sqi_sck_en,
    output logic        o_arb_sqi_mode,
    output logic [3:0]  o_arb_sqi_data,
    input  logic [3:0]  i_arb_sqi_data
);
    localparam int         AW       = ADDR_NIBBLES * 4;
    localparam logic [2:0] ADDR_LD  = 3'(ADDR_NIBBLES - 1);
    localparam logic [2:0] DUMMY_LD = 3'(DUMMY_CYCLES > 0 ? DUMMY_CYCLES - 1 : 0);
    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, DONE} state_t;
    state_t      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic        cs_q, sck_en_q;
    logic        active_d;
    logic [7:0]  cmd_w;
    logic [AW-1:0] addr_ext_w;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 3'd1;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = 3'd1;
                if (i_arb_fetch_req || i_arb_lsu_req) begin
                    state_d = CMD;
                    // owner_q doubles as last owner: on contention the other side wins
                    owner_d = i_arb_lsu_req && (!i_arb_fetch_req || !owner_q);
                    we_d    = owner_d && i_arb_lsu_we;
                    addr_d  = owner_d ? i_arb_lsu_addr : i_arb_fetch_addr;
                    wdata_d = i_arb_lsu_wdata;
                end
            end
            CMD: if (cnt_q == 3'd0) begin
                state_d = ADDR;
                cnt_d   = ADDR_LD;
            end
            ADDR: if (cnt_q == 3'd0) begin
                state_d = (we_q || DUMMY_CYCLES == 0) ? DATA : DUMMY;
                cnt_d   = (we_q || DUMMY_CYCLES == 0) ? 3'd3 : DUMMY_LD;
            end
            DUMMY: if (cnt_q == 3'd0) begin
                state_d = DATA;
                cnt_d   = 3'd3;
            end
            DATA: begin
                rdata_d = we_q ? rdata_q : {rdata_q[11:0], i_arb_sqi_data};
                state_d = (cnt_q == 3'd0) ? DONE : DATA;
            end
            default: state_d = IDLE;
        endcase
    end
    assign active_d = state_d inside {CMD, ADDR, DUMMY, DATA};
    always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
        if (!i_core_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            owner_q  <= 1'b1;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            cs_q     <= 1'b1;
            sck_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owner_q  <= owner_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cs_q     <= !active_d;
            sck_en_q <= active_d;
        end
    end
    assign cmd_w            = we_q ? CMD_WR : CMD_RD;
    assign addr_ext_w       = AW'(addr_q);
    assign o_arb_sqi_mode   = (state_q == DUMMY) || (state_q == DATA && !we_q);
    assign o_arb_sqi_data   = o_arb_sqi_mode  ? 4'h0 :
                              state_q == CMD  ? (cnt_q[0] ? cmd_w[7:4] : cmd_w[3:0]) :
                              state_q == ADDR ? addr_ext_w[{cnt_q, 2'b00} +: 4] :
                              state_q == DATA ? wdata_q[{cnt_q[1:0], 2'b00} +: 4] : 4'h0;
    assign o_arb_fetch_ack  = (state_q == DONE) && !owner_q;
    assign o_arb_lsu_ack    = (state_q == DONE) && owner_q;
    assign o_arb_rdata      = rdata_q;
    assign o_arb_busy       = state_q != IDLE;
    assign o_arb_sqi_cs     = cs_q;
    assign o_arb_sqi_sck_en = sck_en_q;
endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// tb_idli_sqi_arb_m: randomized checks of the SQI arbiter against a nibble-list transaction model
module tb_idli_sqi_arb_m;
    localparam int AN = 6;
    localparam int DC = 2;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        fetch_req = 1'b0, lsu_req = 1'b0, lsu_we = 1'b0;
    logic [15:0] fetch_addr = '0, lsu_addr = '0, lsu_wdata = '0;
    logic [3:0]  sqi_in = '0;
    logic        f_ack, l_ack, o_busy, o_cs, o_sck, o_mode;
    logic [15:0] o_rdata;
    logic [3:0]  o_data;
    typedef struct packed {
        logic [7:0]  lat;
        logic [1:0]  ack;
        logic        cs_ack;
        logic        busy_ack;
        logic [15:0] rdata;
        logic [15:0] mode;
        logic [63:0] nib;
    } txn_t;
    int          n_chk = 0, n_fail = 0, bad_sck = 0;
    logic        last_lsu = 1'b1;
    logic [15:0] exp_rdata = '0;

    always #5 clk = ~clk;

    idli_sqi_arb_m dut (
        .i_core_gck(clk), .i_core_rst_n(rst_n),
        .i_arb_fetch_req(fetch_req), .i_arb_fetch_addr(fetch_addr),
        .i_arb_lsu_req(lsu_req), .i_arb_lsu_we(lsu_we),
        .i_arb_lsu_addr(lsu_addr), .i_arb_lsu_wdata(lsu_wdata),
        .o_arb_fetch_ack(f_ack), .o_arb_lsu_ack(l_ack), .o_arb_rdata(o_rdata),
        .o_arb_busy(o_busy), .o_arb_sqi_cs(o_cs), .o_arb_sqi_sck_en(o_sck),
        .o_arb_sqi_mode(o_mode), .o_arb_sqi_data(o_data), .i_arb_sqi_data(sqi_in)
    );

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected pad-side view of one transaction, built as an ordered list of nibbles
    function automatic txn_t model(input logic own_lsu, input logic we, input logic [15:0] addr,
                                   input logic [15:0] wdata, input logic [15:0] pad);
        txn_t t;
        logic [23:0] a;
        logic [7:0]  c;
        logic [3:0]  q[$];
        logic        m[$];
        t = '0;
        a = {8'h00, addr};
        c = we ? 8'h02 : 8'h03;
        q.push_back(c[7:4]); m.push_back(1'b0);
        q.push_back(c[3:0]); m.push_back(1'b0);
        for (int i = AN - 1; i >= 0; i--) begin q.push_back(a[4*i +: 4]); m.push_back(1'b0); end
        if (!we) for (int i = 0; i < DC; i++) begin q.push_back(4'h0); m.push_back(1'b1); end
        for (int i = 3; i >= 0; i--) begin q.push_back(we ? wdata[4*i +: 4] : 4'h0); m.push_back(!we); end
        foreach (q[i]) begin
            t.nib  = {t.nib[59:0], q[i]};
            t.mode = {t.mode[14:0], m[i]};
        end
        t.lat      = 8'(q.size());
        t.ack      = own_lsu ? 2'b01 : 2'b10;
        t.cs_ack   = 1'b1;
        t.busy_ack = 1'b1;
        t.rdata    = we ? exp_rdata : pad;
        return t;
    endfunction

    // Records the pads from grant to ack and plays pad nibbles back during read data
    task automatic observe(input logic [15:0] pad, input logic scramble, output txn_t o, output int gap);
        int idx;
        bit done;
        idx = -1; done = 0; o = '0; gap = 0;
        for (int c = 0; c < 60 && !done; c++) begin
            tick;
            sqi_in = 4'($urandom);
            if (!o_cs) begin
                idx++;
                o.nib  = {o.nib[59:0], o_data};
                o.mode = {o.mode[14:0], o_mode};
                if (o_sck !== 1'b1) bad_sck++;
                if (idx >= 2 + AN + DC && idx < 6 + AN + DC) sqi_in = pad[4*(5 + AN + DC - idx) +: 4];
                if (scramble && idx == 0) begin
                    lsu_addr = ~lsu_addr; lsu_wdata = ~lsu_wdata; lsu_we = ~lsu_we; fetch_addr = ~fetch_addr;
                end
            end else begin
                if (idx < 0) gap++;
                if (o_sck !== 1'b0) bad_sck++;
            end
            if (f_ack || l_ack) begin
                o.lat = 8'(idx + 1); o.ack = {f_ack, l_ack}; o.cs_ack = o_cs;
                o.busy_ack = o_busy; o.rdata = o_rdata; done = 1;
            end
        end
        if (!done) o.lat = 8'hFF;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) tick;
        n_chk++;
        if ({o_cs, o_sck, o_mode, o_data} !== 7'b1000000) begin
            n_fail++; $display("FAIL reset_pads got %b exp 1000000", {o_cs, o_sck, o_mode, o_data});
        end
        n_chk++;
        if ({f_ack, l_ack, o_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ack_busy got %b exp 000", {f_ack, l_ack, o_busy});
        end
        n_chk++;
        if (o_rdata !== 16'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0000", o_rdata); end
        rst_n = 1'b1; last_lsu = 1'b1; exp_rdata = '0;
    endtask

    task automatic test_fetch_read;
        txn_t obs, exp;
        int gap;
        fetch_addr = 16'h1234; fetch_req = 1'b1;
        exp = model(1'b0, 1'b0, 16'h1234, 16'h0, 16'hBEEF);
        observe(16'hBEEF, 1'b0, obs, gap);
        fetch_req = 1'b0;
        n_chk++;
        if (obs !== exp) begin n_fail++; $display("FAIL fetch_read got %h exp %h", obs, exp); end
        n_chk++;
        if ({obs.lat, obs.nib[55:0], obs.mode[13:0], obs.rdata} !== {8'd14, 56'h03001234000000, 14'b00000000111111, 16'hBEEF}) begin
            n_fail++; $display("FAIL fetch_read_literal got %h/%h/%b/%h", obs.lat, obs.nib, obs.mode, obs.rdata);
        end
        last_lsu = 1'b0; exp_rdata = 16'hBEEF;
    endtask

    task automatic test_lsu_write;
        txn_t obs, exp;
        int gap;
        lsu_addr = 16'h00FF; lsu_wdata = 16'hA5C3; lsu_we = 1'b1; lsu_req = 1'b1;
        exp = model(1'b1, 1'b1, 16'h00FF, 16'hA5C3, 16'h0);
        observe(16'($urandom), 1'b0, obs, gap);
        lsu_req = 1'b0;
        n_chk++;
        if (obs !== exp) begin n_fail++; $display("FAIL lsu_write got %h exp %h", obs, exp); end
        n_chk++;
        if ({obs.lat, obs.nib[47:0], obs.mode[11:0]} !== {8'd12, 48'h020000FFA5C3, 12'h000}) begin
            n_fail++; $display("FAIL lsu_write_literal got %h/%h/%b", obs.lat, obs.nib, obs.mode);
        end
        last_lsu = 1'b1;
    endtask

    task automatic test_contention;
        txn_t obs, exp;
        int gap;
        logic [15:0] p1, p2;
        rst_n = 1'b0; tick; rst_n = 1'b1; last_lsu = 1'b1; exp_rdata = '0;
        fetch_addr = 16'($urandom); lsu_addr = 16'($urandom); lsu_wdata = 16'($urandom); lsu_we = 1'($urandom);
        p1 = 16'($urandom); p2 = 16'($urandom);
        fetch_req = 1'b1; lsu_req = 1'b1;
        exp = model(1'b0, 1'b0, fetch_addr, 16'h0, p1);
        observe(p1, 1'b0, obs, gap);
        fetch_req = 1'b0;
        n_chk++;
        if (obs !== exp) begin n_fail++; $display("FAIL contention_first got %h exp %h", obs, exp); end
        exp_rdata = p1;
        exp = model(1'b1, lsu_we, lsu_addr, lsu_wdata, p2);
        observe(p2, 1'b0, obs, gap);
        lsu_req = 1'b0;
        n_chk++;
        if (obs !== exp) begin n_fail++; $display("FAIL contention_second got %h exp %h", obs, exp); end
        n_chk++;
        if (gap !== 1) begin n_fail++; $display("FAIL cs_gap got %0d idle cycles exp 1 (plus DONE)", gap); end
        last_lsu = 1'b1;
        if (!lsu_we) exp_rdata = p2;
    endtask

    task automatic test_alternate;
        txn_t obs, exp;
        int gap;
        logic own;
        logic [15:0] pad;
        fetch_addr = 16'($urandom); lsu_addr = 16'($urandom); lsu_wdata = 16'($urandom); lsu_we = 1'($urandom);
        fetch_req = 1'b1; lsu_req = 1'b1;
        for (int t = 0; t < 5; t++) begin
            if (t == 4) lsu_req = 1'b0;
            own = (fetch_req && lsu_req) ? !last_lsu : lsu_req;
            pad = 16'($urandom);
            exp = model(own, own & lsu_we, own ? lsu_addr : fetch_addr, lsu_wdata, pad);
            observe(pad, 1'b0, obs, gap);
            n_chk++;
            if (obs !== exp) begin n_fail++; $display("FAIL alternate_%0d got %h exp %h", t, obs, exp); end
            last_lsu = own;
            if (!(own & lsu_we)) exp_rdata = pad;
            if (own) begin
                lsu_addr = 16'($urandom); lsu_wdata = 16'($urandom); lsu_we = 1'($urandom);
            end else fetch_addr = 16'($urandom);
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset_mid;
        txn_t obs, exp;
        int gap, k;
        logic [15:0] pad;
        fetch_addr = 16'($urandom); fetch_req = 1'b1;
        k = 0;
        while (o_cs && k < 20) begin tick; k++; end
        repeat (3) tick;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({o_cs, o_sck, f_ack, l_ack, o_busy} !== 5'b10000) begin
            n_fail++; $display("FAIL reset_mid got %b exp 10000", {o_cs, o_sck, f_ack, l_ack, o_busy});
        end
        tick;
        n_chk++;
        if ({o_cs, f_ack, l_ack} !== 3'b100) begin
            n_fail++; $display("FAIL reset_hold got %b exp 100", {o_cs, f_ack, l_ack});
        end
        rst_n = 1'b1; last_lsu = 1'b1; exp_rdata = '0;
        pad = 16'($urandom);
        exp = model(1'b0, 1'b0, fetch_addr, 16'h0, pad);
        observe(pad, 1'b0, obs, gap);
        fetch_req = 1'b0;
        n_chk++;
        if (obs !== exp) begin n_fail++; $display("FAIL reset_restart got %h exp %h", obs, exp); end
        last_lsu = 1'b0; exp_rdata = pad;
    endtask

    task automatic test_capture;
        txn_t obs, exp;
        int gap;
        logic [15:0] a, w, pad;
        for (int t = 0; t < 2; t++) begin
            a = 16'($urandom); w = 16'($urandom); pad = 16'($urandom);
            lsu_addr = a; lsu_wdata = w; lsu_we = 1'(t); lsu_req = 1'b1;
            exp = model(1'b1, 1'(t), a, w, pad);
            observe(pad, 1'b1, obs, gap);
            lsu_req = 1'b0;
            n_chk++;
            if (obs !== exp) begin n_fail++; $display("FAIL capture_we%0d got %h exp %h", t, obs, exp); end
            last_lsu = 1'b1;
            if (t == 0) exp_rdata = pad;
        end
    endtask

    task automatic test_random;
        txn_t obs, exp;
        int gap;
        logic own;
        logic [15:0] pad;
        for (int t = 0; t < 13; t++) begin
            if (t < 12 && !fetch_req && 1'($urandom)) begin fetch_addr = 16'($urandom); fetch_req = 1'b1; end
            if (t < 12 && !lsu_req && 1'($urandom)) begin
                lsu_addr = 16'($urandom); lsu_wdata = 16'($urandom); lsu_we = 1'($urandom); lsu_req = 1'b1;
            end
            if (!fetch_req && !lsu_req) begin fetch_addr = 16'($urandom); fetch_req = 1'b1; end
            own = (fetch_req && lsu_req) ? !last_lsu : lsu_req;
            pad = 16'($urandom);
            exp = model(own, own & lsu_we, own ? lsu_addr : fetch_addr, lsu_wdata, pad);
            observe(pad, 1'b0, obs, gap);
            n_chk++;
            if (obs !== exp) begin n_fail++; $display("FAIL random_%0d got %h exp %h", t, obs, exp); end
            last_lsu = own;
            if (!(own & lsu_we)) exp_rdata = pad;
            if (own) lsu_req = 1'b0; else fetch_req = 1'b0;
        end
    endtask

    initial begin
        test_reset;
        test_fetch_read;
        test_lsu_write;
        test_contention;
        test_alternate;
        test_reset_mid;
        test_capture;
        test_random;
        n_chk++;
        if (bad_sck !== 0) begin n_fail++; $display("FAIL sck_en_vs_cs got %0d bad cycles exp 0", bad_sck); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end
endmodule
